vga_bg_pixel_source: RTL and testbench



---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_sync_rom.sv | 38 +++
 rtl/vga_bg_pixel_source.sv | 89 ++++++++
 tb/tb_vga_bg_pixel_source.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared geometry, colour layout and ROM image content
// for the VGA background pixel path.
package vga_pkg;

    localparam int H_RES          = 640;
    localparam int V_RES          = 480;
    localparam int GRID_COL_PITCH = 40;
    localparam int GRID_ROW_PITCH = 53;

    localparam logic [23:0] EDGE_COLOR = 24'h444444;

    localparam string IMG_INIT = "img_data.mif";
    localparam string PAL_INIT = "img_index.mif";

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } bgr_t;

    // Index image is a byte ramp; palette maps k to grey {k,k,k}.
    function automatic bgr_t rom_word(
        input logic       pal,
        input logic [7:0] a
    );
        bgr_t w;
        w   = '0;
        w.r = a;
        if (pal) begin
            w.b = a;
            w.g = a;
        end
        return w;
    endfunction

endpackage

// File: rtl/vga_sync_rom.sv
// Synchronous-read ROM with selectable clock edge; contents
// are chosen by the image name it is built for.
module vga_sync_rom
    import vga_pkg::*;
#(
    parameter int    WIDTH     = 8,
    parameter int    DEPTH     = 256,
    parameter string INIT_FILE = "",
    parameter bit    NEG_EDGE  = 1'b0
) (
    input  logic                     clk_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    output logic [WIDTH-1:0]         data_o
);

    localparam bit IS_PAL = (INIT_FILE == PAL_INIT);

    logic [WIDTH-1:0] rd_d;
    logic [WIDTH-1:0] data_q;

    // Addresses beyond the image read as zero.
    always_comb begin
        rd_d = '0;
        if (32'(addr_i) < DEPTH)
            rd_d = WIDTH'(rom_word(IS_PAL, addr_i[7:0]));
    end

    if (NEG_EDGE) begin : g_neg
        always_ff @(negedge clk_i)
            data_q <= rd_d;
    end else begin : g_pos
        always_ff @(posedge clk_i)
            data_q <= rd_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/vga_bg_pixel_source.sv
// Background pixel source: address -> palette index -> BGR,
// with a fixed-colour grid overlaid, one cycle latency.
module vga_bg_pixel_source #(
    parameter int          H_RES          = vga_pkg::H_RES,
    parameter int          V_RES          = vga_pkg::V_RES,
    parameter int          GRID_COL_PITCH = vga_pkg::GRID_COL_PITCH,
    parameter int          GRID_ROW_PITCH = vga_pkg::GRID_ROW_PITCH,
    parameter logic [23:0] EDGE_COLOR     = vga_pkg::EDGE_COLOR,
    parameter string       IMG_INIT       = vga_pkg::IMG_INIT,
    parameter string       PAL_INIT       = vga_pkg::PAL_INIT
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic [18:0] addr,
    output logic [23:0] bgr_out,
    output logic        grid_edge,
    output logic [9:0]  pix_row,
    output logic [9:0]  pix_col
);

    import vga_pkg::*;

    localparam int NPIX = H_RES * V_RES;

    logic [7:0] idx;
    bgr_t       pal;
    logic       in_range;
    logic       on_grid;
    logic       inr_d;
    logic       inr_q;
    logic       edge_d;
    logic       edge_q;

    assign pix_row  = 10'(addr / 19'(H_RES));
    assign pix_col  = 10'(addr % 19'(H_RES));
    assign in_range = 32'(addr) < NPIX;

    assign on_grid =
        (pix_col % 10'(GRID_COL_PITCH) == '0) ||
        (pix_row % 10'(GRID_ROW_PITCH) == '0);

    assign inr_d  = in_range;
    assign edge_d = in_range && on_grid;

    // Index lands half a cycle in, so the palette can read it
    // on the next rising edge alongside the flag registers.
    vga_sync_rom #(
        .WIDTH    (8),
        .DEPTH    (NPIX),
        .INIT_FILE(IMG_INIT),
        .NEG_EDGE (1'b1)
    ) u_img_rom (
        .clk_i (iVGA_CLK),
        .addr_i(addr),
        .data_o(idx)
    );

    vga_sync_rom #(
        .WIDTH    (24),
        .DEPTH    (256),
        .INIT_FILE(PAL_INIT),
        .NEG_EDGE (1'b0)
    ) u_pal_rom (
        .clk_i (iVGA_CLK),
        .addr_i(idx),
        .data_o(pal)
    );

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            inr_q  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            inr_q  <= inr_d;
            edge_q <= edge_d;
        end
    end

    always_comb begin
        bgr_out = pal;
        if (edge_q)
            bgr_out = EDGE_COLOR;
        else if (!inr_q)
            bgr_out = '0;
    end

    assign grid_edge = edge_q;

endmodule

// File: tb/tb_vga_bg_pixel_source.sv
// Bench for vga_bg_pixel_source: vector table, streaming
// scoreboard and asynchronous reset sequences.
module tb_vga_bg_pixel_source;

    typedef struct {
        logic [18:0] a;
        logic [9:0]  row;
        logic [9:0]  col;
        logic [23:0] bgr;
        logic        edg;
        string       nm;
    } vec_t;

    typedef struct {
        logic [23:0] bgr;
        logic        edg;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [18:0] addr;
    logic [23:0] bgr_out;
    logic        grid_edge;
    logic [9:0]  pix_row;
    logic [9:0]  pix_col;

    exp_t sb[$];
    vec_t tv[10];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    vga_bg_pixel_source dut (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .addr     (addr),
        .bgr_out  (bgr_out),
        .grid_edge(grid_edge),
        .pix_row  (pix_row),
        .pix_col  (pix_col)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [18:0] a,
                                   input string nm);
        exp_t e;
        int   r;
        int   c;
        r     = int'(a) / 640;
        c     = int'(a) % 640;
        e.bgr = 24'h0;
        e.edg = 1'b0;
        e.nm  = nm;
        if (int'(a) < 307200) begin
            if (c % 40 == 0 || r % 53 == 0) begin
                e.edg = 1'b1;
                e.bgr = 24'h444444;
            end else begin
                e.bgr = {a[7:0], a[7:0], a[7:0]};
            end
        end
        return e;
    endfunction

    task automatic drain();
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({x.nm, "_bgr"}, 32'(bgr_out), 32'(x.bgr));
            chk({x.nm, "_edge"}, 32'(grid_edge), 32'(x.edg));
        end
    endtask

    // Entered at posedge+1: retire the previous address, drive
    // the next one, then advance to the following posedge+1.
    task automatic step(input logic [18:0] a, input exp_t e);
        drain();
        addr = a;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0] = '{19'd641,    10'd1,   10'd1,   24'h818181, 1'b0, "interior"};
        tv[1] = '{19'd0,      10'd0,   10'd0,   24'h444444, 1'b1, "origin"};
        tv[2] = '{19'd680,    10'd1,   10'd40,  24'h444444, 1'b1, "vline"};
        tv[3] = '{19'd33927,  10'd53,  10'd7,   24'h444444, 1'b1, "hline"};
        tv[4] = '{19'd34567,  10'd54,  10'd7,   24'h070707, 1'b0, "neigh"};
        tv[5] = '{19'd639,    10'd0,   10'd639, 24'h444444, 1'b1, "col639"};
        tv[6] = '{19'd307199, 10'd479, 10'd639, 24'hffffff, 1'b0, "last"};
        tv[7] = '{19'd306560, 10'd479, 10'd0,   24'h444444, 1'b1, "row479"};
        tv[8] = '{19'd307200, 10'd480, 10'd0,   24'h000000, 1'b0, "oor"};
        tv[9] = '{19'd524287, 10'd819, 10'd127, 24'h000000, 1'b0, "oormax"};

        rst_n = 1'b0;
        addr  = 19'd641;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bgr", 32'(bgr_out), 32'h0);
        chk("rst_edge", 32'(grid_edge), 32'h0);
        rst_n = 1'b1;
        sb.push_back('{24'h818181, 1'b0, "rst_rel"});
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            step(tv[i].a, '{tv[i].bgr, tv[i].edg, tv[i].nm});
            chk({tv[i].nm, "_row"}, 32'(pix_row), 32'(tv[i].row));
            chk({tv[i].nm, "_col"}, 32'(pix_col), 32'(tv[i].col));
        end

        for (int a = 640; a <= 700; a++)
            step(19'(a), model(19'(a), "stream"));
        step(19'd0, model(19'd0, "pre_rst"));
        drain();

        #2;
        rst_n = 1'b0;
        #1;
        chk("async_bgr", 32'(bgr_out), 32'h0);
        chk("async_edge", 32'(grid_edge), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(19'd34567, model(19'd34567, "post_rst"));
        step(19'd0, model(19'd0, "post_grid"));
        step(19'd307200, model(19'd307200, "post_oor"));
        step(19'd1, model(19'd1, "post_wrap"));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
